decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe_pkg.sv | 71 +++++++
 rtl/decode_pipe_core.sv | 101 ++++++++++
 rtl/decode_pipe.sv | 110 +++++++++++
 tb/tb_decode_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pipe_pkg.sv
// Shared types for the decode pipe: control bundle, opcode constants, ALU op encodings.
package decode_pipe_pkg;

  typedef logic [31:0] word;
  typedef logic [4:0]  reg_index;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [4:0] {
    OP_ALU_ADD, OP_ALU_SUB, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU, OP_ALU_XOR,
    OP_ALU_SRL, OP_ALU_SRA, OP_ALU_OR, OP_ALU_AND, OP_ALU_PASS_B,
    OP_ALU_MUL, OP_ALU_MULH, OP_ALU_MULHSU, OP_ALU_MULHU,
    OP_ALU_DIV, OP_ALU_DIVU, OP_ALU_REM, OP_ALU_REMU
  } alu_op_t;

  typedef enum logic {ALU_REG_OP, ALU_IMM_OP} alu_src_t;
  typedef enum logic {ALU_A_REG, ALU_A_PC} alu_a_t;
  typedef enum logic [1:0] {MEM_SKIP_OP, MEM_LOAD_OP, MEM_STORE_OP} mem_op_t;
  typedef enum logic [1:0] {NO_REG_DATA, REG_ALU_DATA, REG_MEM_DATA, REG_PC4_DATA} reg_file_op_t;

  // funct3 carries access width for loads/stores and the condition for branches
  typedef struct packed {
    alu_op_t      alu_op;
    alu_a_t       alu_a;
    alu_src_t     alu_src;
    mem_op_t      mem_op;
    logic [2:0]   funct3;
    reg_file_op_t reg_file_op;
    logic         branch;
    logic         jump;
  } control_signals_t;

  localparam control_signals_t CTRL_DEFAULT = '{
    alu_op: OP_ALU_ADD, alu_a: ALU_A_REG, alu_src: ALU_REG_OP, mem_op: MEM_SKIP_OP,
    funct3: 3'b000, reg_file_op: NO_REG_DATA, branch: 1'b0, jump: 1'b0};

  function automatic alu_op_t alu_base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_ALU_SUB : OP_ALU_ADD;
      3'b001:  return OP_ALU_SLL;
      3'b010:  return OP_ALU_SLT;
      3'b011:  return OP_ALU_SLTU;
      3'b100:  return OP_ALU_XOR;
      3'b101:  return alt ? OP_ALU_SRA : OP_ALU_SRL;
      3'b110:  return OP_ALU_OR;
      default: return OP_ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t alu_m_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ALU_MUL;
      3'b001:  return OP_ALU_MULH;
      3'b010:  return OP_ALU_MULHSU;
      3'b011:  return OP_ALU_MULHU;
      3'b100:  return OP_ALU_DIV;
      3'b101:  return OP_ALU_DIVU;
      3'b110:  return OP_ALU_REM;
      default: return OP_ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_core.sv
// Combinational RV32/64 base (+ optional M) instruction decoder.
module decode_core
  import decode_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]      instr,
  output control_signals_t ctrl,
  output reg_index         rs1_idx,
  output reg_index         rs2_idx,
  output reg_index         rd_idx,
  output logic [XLEN-1:0]  imm,
  output logic             illegal
);

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic shamt_ok;
  logic bad;
  control_signals_t c;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1_idx = instr[19:15];
  assign rs2_idx = instr[24:20];
  assign rd_idx  = instr[11:7];

  assign imm_i = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign imm_s = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // RV64 shifts take a 6-bit shamt, leaving one fewer qualifier bit
  assign shamt_ok = (XLEN == 64) ? (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)
                                 : (f7 == 7'b0000000 || f7 == 7'b0100000);

  always_comb begin
    c   = CTRL_DEFAULT;
    bad = 1'b0;
    imm = '0;
    case (opc)
      OPC_OP: begin
        c.reg_file_op = REG_ALU_DATA;
        if (f7 == 7'b0000000)                                   c.alu_op = alu_base_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) c.alu_op = alu_base_op(f3, 1'b1);
        else if (f7 == 7'b0000001 && ENABLE_M)                  c.alu_op = alu_m_op(f3);
        else                                                    bad = 1'b1;
      end
      OPC_OP_IMM: begin
        c.alu_src = ALU_IMM_OP; c.reg_file_op = REG_ALU_DATA; imm = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          c.alu_op = alu_base_op(f3, instr[30]);
          bad      = !shamt_ok;
        end else begin
          c.alu_op = alu_base_op(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        c.alu_src = ALU_IMM_OP; c.mem_op = MEM_LOAD_OP; c.funct3 = f3;
        c.reg_file_op = REG_MEM_DATA; imm = imm_i;
      end
      OPC_STORE: begin
        c.alu_src = ALU_IMM_OP; c.mem_op = MEM_STORE_OP; c.funct3 = f3; imm = imm_s;
      end
      OPC_BRANCH: begin
        c.alu_op = OP_ALU_SUB; c.branch = 1'b1; c.funct3 = f3; imm = imm_b;
        bad = (f3 == 3'b010 || f3 == 3'b011);
      end
      OPC_JAL: begin
        c.alu_a = ALU_A_PC; c.alu_src = ALU_IMM_OP; c.jump = 1'b1;
        c.reg_file_op = REG_PC4_DATA; imm = imm_j;
      end
      OPC_JALR: begin
        c.alu_src = ALU_IMM_OP; c.jump = 1'b1; c.mem_op = MEM_SKIP_OP;
        c.reg_file_op = REG_PC4_DATA; imm = imm_i;
        bad = (f3 != 3'b000);
      end
      OPC_LUI: begin
        c.alu_op = OP_ALU_PASS_B; c.alu_src = ALU_IMM_OP; c.reg_file_op = REG_ALU_DATA; imm = imm_u;
      end
      OPC_AUIPC: begin
        c.alu_a = ALU_A_PC; c.alu_src = ALU_IMM_OP; c.reg_file_op = REG_ALU_DATA; imm = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c   = CTRL_DEFAULT;
      imm = '0;
    end else if (rd_idx == 5'd0) begin
      c.reg_file_op = NO_REG_DATA;
    end
  end

  assign ctrl    = c;
  assign illegal = bad;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: decoder ahead of a 2-entry (output + skid) elastic buffer, plus illegal counter.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output control_signals_t out_ctrl,
  output reg_index         out_rs1_idx,
  output reg_index         out_rs2_idx,
  output reg_index         out_rd_idx,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    control_signals_t ctrl;
    reg_index         rs1;
    reg_index         rs2;
    reg_index         rd;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } entry_t;

  control_signals_t d_ctrl;
  reg_index         d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0]  d_imm;
  logic             d_ill;
  entry_t           dec, out_q, skid_q;
  logic             out_vld, skid_vld, rdy_q;
  logic             accept, retire;
  logic [CNT_W-1:0] cnt;

  decode_core #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_core (
    .instr   (in_instr),
    .ctrl    (d_ctrl),
    .rs1_idx (d_rs1),
    .rs2_idx (d_rs2),
    .rd_idx  (d_rd),
    .imm     (d_imm),
    .illegal (d_ill)
  );

  assign dec    = '{ctrl: d_ctrl, rs1: d_rs1, rs2: d_rs2, rd: d_rd, imm: d_imm, pc: in_pc, illegal: d_ill};
  assign accept = in_valid && rdy_q;
  assign retire = out_vld && out_ready;

  // rdy_q tracks "skid empty" one edge late; it also stays low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (retire || !out_vld) begin
      rdy_q <= 1'b1;
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= !skid_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!flush && retire && out_q.illegal && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign in_ready    = rdy_q;
  assign out_valid   = out_vld;
  assign out_ctrl    = out_q.ctrl;
  assign out_rs1_idx = out_q.rs1;
  assign out_rs2_idx = out_q.rs2;
  assign out_rd_idx  = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench: two decode_pipe instances (M on / M off with 2-bit counter) on shared stimulus.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic in_ready_m, out_valid_m, out_ill_m;
  control_signals_t ctrl_m;
  reg_index rs1_m, rs2_m, rd_m;
  logic [31:0] imm_m, pc_m;
  logic [15:0] cnt_m;

  logic in_ready_b, out_valid_b, out_ill_b;
  control_signals_t ctrl_b;
  reg_index rs1_b, rs2_b, rd_b;
  logic [31:0] imm_b, pc_b;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_ctrl(ctrl_m), .out_rs1_idx(rs1_m), .out_rs2_idx(rs2_m), .out_rd_idx(rd_m),
    .out_imm(imm_m), .out_pc(pc_m), .out_illegal(out_ill_m), .illegal_cnt(cnt_m));

  decode_pipe #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(ctrl_b), .out_rs1_idx(rs1_b), .out_rs2_idx(rs2_b), .out_rd_idx(rd_b),
    .out_imm(imm_b), .out_pc(pc_b), .out_illegal(out_ill_b), .illegal_cnt(cnt_b));

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { control_signals_t ctrl; logic [31:0] imm; logic ill; } exp_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } item_t;

  item_t q[$];
  bit    mrdy = 1'b0;
  int    mcnt_m = 0, mcnt_b = 0;

  function automatic exp_t mdec(input logic [31:0] i, input bit m);
    exp_t e;
    alu_op_t base[8] = '{OP_ALU_ADD, OP_ALU_SLL, OP_ALU_SLT, OP_ALU_SLTU,
                         OP_ALU_XOR, OP_ALU_SRL, OP_ALU_OR, OP_ALU_AND};
    alu_op_t mops[8] = '{OP_ALU_MUL, OP_ALU_MULH, OP_ALU_MULHSU, OP_ALU_MULHU,
                         OP_ALU_DIV, OP_ALU_DIVU, OP_ALU_REM, OP_ALU_REMU};
    logic [2:0]  f3  = i[14:12];
    logic [6:0]  f7  = i[31:25];
    logic [11:0] s12 = {i[31:25], i[11:7]};
    logic [12:0] b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    logic [20:0] j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    int ii = $signed(i[31:20]);
    int si = $signed(s12);
    int bi = $signed(b13);
    int ji = $signed(j21);
    e.ctrl = CTRL_DEFAULT; e.imm = '0; e.ill = 1'b0;
    case (i[6:0])
      7'h33: begin
        e.ctrl.reg_file_op = REG_ALU_DATA;
        if (f7 == 7'h00) e.ctrl.alu_op = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl.alu_op = OP_ALU_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl.alu_op = OP_ALU_SRA;
        else if (f7 == 7'h01 && m) e.ctrl.alu_op = mops[f3];
        else e.ill = 1'b1;
      end
      7'h13: begin
        e.ctrl.alu_src = ALU_IMM_OP; e.ctrl.reg_file_op = REG_ALU_DATA; e.imm = ii;
        e.ctrl.alu_op = (f3 == 3'd5 && i[30]) ? OP_ALU_SRA : base[f3];
        if (f3 == 3'd1 || f3 == 3'd5) e.ill = !(f7 == 7'h00 || f7 == 7'h20);
      end
      7'h03: begin
        e.ctrl.alu_src = ALU_IMM_OP; e.ctrl.mem_op = MEM_LOAD_OP; e.ctrl.funct3 = f3;
        e.ctrl.reg_file_op = REG_MEM_DATA; e.imm = ii;
      end
      7'h23: begin
        e.ctrl.alu_src = ALU_IMM_OP; e.ctrl.mem_op = MEM_STORE_OP; e.ctrl.funct3 = f3; e.imm = si;
      end
      7'h63: begin
        e.ctrl.alu_op = OP_ALU_SUB; e.ctrl.branch = 1'b1; e.ctrl.funct3 = f3; e.imm = bi;
        e.ill = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h6f: begin
        e.ctrl.alu_a = ALU_A_PC; e.ctrl.alu_src = ALU_IMM_OP; e.ctrl.jump = 1'b1;
        e.ctrl.reg_file_op = REG_PC4_DATA; e.imm = ji;
      end
      7'h67: begin
        e.ctrl.alu_src = ALU_IMM_OP; e.ctrl.jump = 1'b1; e.ctrl.reg_file_op = REG_PC4_DATA;
        e.imm = ii; e.ill = (f3 != 3'd0);
      end
      7'h37: begin
        e.ctrl.alu_op = OP_ALU_PASS_B; e.ctrl.alu_src = ALU_IMM_OP;
        e.ctrl.reg_file_op = REG_ALU_DATA; e.imm = i & 32'hFFFFF000;
      end
      7'h17: begin
        e.ctrl.alu_a = ALU_A_PC; e.ctrl.alu_src = ALU_IMM_OP;
        e.ctrl.reg_file_op = REG_ALU_DATA; e.imm = i & 32'hFFFFF000;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.ctrl = CTRL_DEFAULT; e.imm = '0; end
    else if (i[11:7] == 5'd0) e.ctrl.reg_file_op = NO_REG_DATA;
    return e;
  endfunction

  task automatic update();
    bit acc, ret;
    item_t it;
    exp_t e1, e0;
    if (!rst_n) return;
    if (flush) begin
      q.delete();
      mrdy = 1'b1;
      return;
    end
    acc = in_valid && mrdy;
    ret = (q.size() != 0) && out_ready;
    if (ret) begin
      it = q.pop_front();
      e1 = mdec(it.instr, 1'b1);
      e0 = mdec(it.instr, 1'b0);
      if (e1.ill && mcnt_m < 65535) mcnt_m++;
      if (e0.ill && mcnt_b < 3) mcnt_b++;
    end
    if (acc) q.push_back('{in_instr, in_pc});
    mrdy = (q.size() < 2);
  endtask

  task automatic check_model();
    exp_t e1, e0;
    logic [14:0] idx;
    chk("in_ready_m", 64'(in_ready_m), 64'(mrdy));
    chk("in_ready_b", 64'(in_ready_b), 64'(mrdy));
    chk("out_valid_m", 64'(out_valid_m), 64'(q.size() != 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(q.size() != 0));
    chk("cnt_m", 64'(cnt_m), 64'(mcnt_m));
    chk("cnt_b", 64'(cnt_b), 64'(mcnt_b));
    if (q.size() != 0) begin
      e1  = mdec(q[0].instr, 1'b1);
      e0  = mdec(q[0].instr, 1'b0);
      idx = {q[0].instr[19:15], q[0].instr[24:20], q[0].instr[11:7]};
      chk("ctrl_m", 64'(ctrl_m), 64'(e1.ctrl));
      chk("imm_m", 64'(imm_m), 64'(e1.imm));
      chk("ill_m", 64'(out_ill_m), 64'(e1.ill));
      chk("pc_m", 64'(pc_m), 64'(q[0].pc));
      chk("idx_m", 64'({rs1_m, rs2_m, rd_m}), 64'(idx));
      chk("ctrl_b", 64'(ctrl_b), 64'(e0.ctrl));
      chk("imm_b", 64'(imm_b), 64'(e0.imm));
      chk("ill_b", 64'(out_ill_b), 64'(e0.ill));
      chk("pc_b", 64'(pc_b), 64'(q[0].pc));
      chk("idx_b", 64'({rs1_b, rs2_b, rd_b}), 64'(idx));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    #1;
    check_model();
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, 64'({out_valid_m, out_valid_b}), 64'(0));
    chk({tag, "_rdy"}, 64'({in_ready_m, in_ready_b}), 64'(0));
    chk({tag, "_cnt"}, 64'({cnt_m, cnt_b}), 64'(0));
    chk({tag, "_ctrl"}, 64'(ctrl_m), 64'(CTRL_DEFAULT));
    chk({tag, "_data"}, 64'({imm_m, pc_m}), 64'(0));
    chk({tag, "_ill_idx"}, 64'({out_ill_m, rs1_m, rs2_m, rd_m}), 64'(0));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] instr; alu_op_t op_m; bit ill_m; bit ill_b; reg_file_op_t reg_m; logic [31:0] imm_m;
  } vec_t;
  vec_t vt[$];

  initial begin
    vt.push_back('{32'h022081B3, OP_ALU_MUL,    1'b0, 1'b1, REG_ALU_DATA, 32'h0});        // mul x3,x1,x2
    vt.push_back('{32'h00000033, OP_ALU_ADD,    1'b0, 1'b0, NO_REG_DATA,  32'h0});        // add x0,x0,x0
    vt.push_back('{32'h00000000, OP_ALU_ADD,    1'b1, 1'b1, NO_REG_DATA,  32'h0});
    vt.push_back('{32'h800002B7, OP_ALU_PASS_B, 1'b0, 1'b0, REG_ALU_DATA, 32'h80000000}); // lui
    vt.push_back('{32'hFFF00093, OP_ALU_ADD,    1'b0, 1'b0, REG_ALU_DATA, 32'hFFFFFFFF}); // addi -1
    vt.push_back('{32'h000090E7, OP_ALU_ADD,    1'b1, 1'b1, NO_REG_DATA,  32'h0});        // jalr f3=1
    vt.push_back('{32'h00002063, OP_ALU_ADD,    1'b1, 1'b1, NO_REG_DATA,  32'h0});        // branch f3=2
    vt.push_back('{32'h02109093, OP_ALU_ADD,    1'b1, 1'b1, NO_REG_DATA,  32'h0});        // slli bad hi
    vt.push_back('{32'h4030D093, OP_ALU_SRA,    1'b0, 1'b0, REG_ALU_DATA, 32'h00000403}); // srai
    vt.push_back('{32'h402081B3, OP_ALU_SUB,    1'b0, 1'b0, REG_ALU_DATA, 32'h0});        // sub
    vt.push_back('{32'h402091B3, OP_ALU_ADD,    1'b1, 1'b1, NO_REG_DATA,  32'h0});        // bad R
    vt.push_back('{32'hFFC0A103, OP_ALU_ADD,    1'b0, 1'b0, REG_MEM_DATA, 32'hFFFFFFFC}); // lw -4
    vt.push_back('{32'h0220C1B3, OP_ALU_DIV,    1'b0, 1'b1, REG_ALU_DATA, 32'h0});        // div
    vt.push_back('{32'hFFFFF117, OP_ALU_ADD,    1'b0, 1'b0, REG_ALU_DATA, 32'hFFFFF000}); // auipc
    vt.push_back('{32'hFE209CE3, OP_ALU_SUB,    1'b0, 1'b0, NO_REG_DATA,  32'hFFFFFFF8}); // bne -8

    // reset state
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // single addi: visible one cycle after acceptance
    drive(1, 32'h00500093, 32'h100, 1, 0);
    tick();
    chk("addi_vld", 64'(out_valid_m), 64'(1));
    chk("addi_op", 64'(ctrl_m.alu_op), 64'(OP_ALU_ADD));
    chk("addi_src", 64'(ctrl_m.alu_src), 64'(ALU_IMM_OP));
    chk("addi_imm_rd", 64'({imm_m, rd_m}), 64'({32'd5, 5'd1}));
    chk("addi_wr", 64'(ctrl_m.reg_file_op), 64'(REG_ALU_DATA));
    drive(0, 0, 0, 1, 0);
    tick();

    foreach (vt[k]) begin
      drive(1, vt[k].instr, 32'h1000 + 32'(k) * 4, 1, 0);
      tick();
      chk("vec_op_m", 64'(ctrl_m.alu_op), 64'(vt[k].op_m));
      chk("vec_ill_m", 64'(out_ill_m), 64'(vt[k].ill_m));
      chk("vec_reg_m", 64'(ctrl_m.reg_file_op), 64'(vt[k].reg_m));
      chk("vec_imm_m", 64'(imm_m), 64'(vt[k].imm_m));
      chk("vec_ill_b", 64'(out_ill_b), 64'(vt[k].ill_b));
      if (vt[k].ill_b) chk("vec_ctrl_b", 64'(ctrl_b), 64'(CTRL_DEFAULT));
      drive(0, 0, 0, 1, 0);
      tick();
      if (k == 0) chk("mul_cnt_b", 64'(cnt_b), 64'(1));
    end
    chk("sat_cnt_b", 64'(cnt_b), 64'(3));
    chk("tot_cnt_m", 64'(cnt_m), 64'(5));

    // backpressure: three back-to-back, out_ready low for 3 cycles
    drive(1, 32'h00100093, 32'h200, 0, 0); tick();
    drive(1, 32'h00200093, 32'h204, 0, 0); tick();
    drive(1, 32'h00300093, 32'h208, 0, 0); tick();
    chk("bp_rdy", 64'(in_ready_m), 64'(0));
    chk("bp_hold", 64'(imm_m), 64'(1));
    drive(1, 32'h00300093, 32'h208, 1, 0); tick();
    chk("bp_second", 64'(imm_m), 64'(2));
    tick();
    chk("bp_third", 64'(imm_m), 64'(3));
    drive(0, 0, 0, 1, 0); tick();
    chk("bp_empty", 64'(out_valid_m), 64'(0));

    // flush with both entries full of illegal words
    drive(1, 32'h00000000, 32'h300, 0, 0); tick(); tick();
    drive(1, 32'h00000000, 32'h308, 1, 1); tick();
    chk("fl_vld", 64'(out_valid_m), 64'(0));
    chk("fl_rdy", 64'(in_ready_m), 64'(1));
    chk("fl_cnt", 64'(cnt_m), 64'(5));
    drive(0, 0, 0, 1, 0); tick();

    // reset asserted mid-operation
    drive(1, 32'h00700093, 32'h400, 0, 0); tick(); tick();
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    q.delete(); mrdy = 1'b0; mcnt_m = 0; mcnt_b = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] r;
      logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h7b};
      r = $urandom;
      if ($urandom_range(0, 3) == 0) r = vt[$urandom_range(0, vt.size() - 1)].instr;
      else begin
        r[6:0] = ops[$urandom_range(0, 9)];
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      drive($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
